// File: rtl/fsm_vector_gen.sv
// Purpose: programmable 5-state Moore reference model; emits one FSM test vector per legal stimulus and scores the DUT output.
// Latency: stimulus -> vector 1 cycle; vector -> mismatch pulse 2 cycles (DUT output sampled in the cycle after the vector).
// Backpressure: none; stimuli arriving outside RUN are dropped, and illegal stimuli are dropped with an in_err pulse.
//
// Ports:
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_cfg_we/_sel/_state/  table write port, accepted only while IDLE
//     _in/_data            (sel=0: next-state entry [state][in], sel=1: output entry [state])
//   i_start, i_stop        IDLE->RUN (model state cleared), RUN->DRAIN
//   i_stim_valid, i_stim_in  stimulus symbol
//   i_dut_out              DUT Moore output, sampled the cycle after o_vec_valid
//   o_vec_valid, o_in_drv, o_cs, o_ns, o_exp_out   vector to the DUT
//   o_cfg_err, o_in_err, o_mismatch, o_done        single-cycle status pulses
//   o_mismatch_cnt         saturating count of failed compares
module fsm_vector_gen #(
  parameter int NUM_ST = 5,
  parameter int ST_W   = 3,
  parameter int OUT_W  = 4,
  parameter int ERR_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_cfg_we,
  input  logic             i_cfg_sel,
  input  logic [ST_W-1:0]  i_cfg_state,
  input  logic [ST_W-1:0]  i_cfg_in,
  input  logic [OUT_W-1:0] i_cfg_data,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_stim_valid,
  input  logic [ST_W-1:0]  i_stim_in,
  input  logic [OUT_W-1:0] i_dut_out,
  output logic             o_vec_valid,
  output logic [ST_W-1:0]  o_in_drv,
  output logic [ST_W-1:0]  o_cs,
  output logic [ST_W-1:0]  o_ns,
  output logic [OUT_W-1:0] o_exp_out,
  output logic             o_cfg_err,
  output logic             o_in_err,
  output logic             o_mismatch,
  output logic [ERR_W-1:0] o_mismatch_cnt,
  output logic             o_done
);

  // One extra bit so the legality compare stays correct even if NUM_ST == 2**ST_W.
  localparam logic [ST_W:0] LP_NUM_ST = (ST_W+1)'(NUM_ST);

  function automatic logic f_legal(input logic [ST_W-1:0] v);
    return ({1'b0, v} < LP_NUM_ST);
  endfunction

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,
    CTL_RUN   = 2'd1,
    CTL_DRAIN = 2'd2
  } ctl_t;

  // One issued vector, kept as a unit so all fields update together.
  typedef struct packed {
    logic [ST_W-1:0]  in_drv;
    logic [ST_W-1:0]  cs;
    logic [ST_W-1:0]  ns;
    logic [OUT_W-1:0] exp_out;
  } vec_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ctl_t             r_ctl;
  ctl_t             w_ctl_nxt;

  logic [ST_W-1:0]  r_nt [NUM_ST][NUM_ST];  // next-state table [state][input]
  logic [OUT_W-1:0] r_ot [NUM_ST];          // Moore output table [state]

  logic [ST_W-1:0]  r_m;                    // model current state
  vec_t             r_vec;
  logic             r_vec_vld;
  logic             r_cfg_err;
  logic             r_in_err;
  logic             r_done;
  logic             r_cmp_pend;             // a vector went out last cycle; DUT output is due now
  logic [OUT_W-1:0] r_cmp_exp;              // expected output of that vector
  logic             r_mismatch;
  logic [ERR_W-1:0] r_mm_cnt;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic             w_is_idle;
  logic             w_is_run;
  logic             w_stim_legal;
  logic             w_issue;
  logic             w_stim_bad;
  logic             w_cfg_legal;
  logic             w_cfg_wr;
  logic             w_cfg_bad;
  logic             w_start;
  logic             w_done;
  logic             w_cmp_fail;
  logic [ST_W-1:0]  w_ns;
  logic [OUT_W-1:0] w_exp;

  assign w_is_idle    = (r_ctl == CTL_IDLE);
  assign w_is_run     = (r_ctl == CTL_RUN);

  assign w_stim_legal = f_legal(i_stim_in);
  assign w_issue      = w_is_run && i_stim_valid && w_stim_legal;
  assign w_stim_bad   = w_is_run && i_stim_valid && !w_stim_legal;

  // Output-entry writes only need a legal row; next-state writes also need a
  // legal column and a legal target state.
  assign w_cfg_legal  = f_legal(i_cfg_state) &&
                        (i_cfg_sel || (f_legal(i_cfg_in) && f_legal(i_cfg_data[ST_W-1:0])));
  assign w_cfg_wr     = w_is_idle && i_cfg_we && w_cfg_legal;
  assign w_cfg_bad    = w_is_idle && i_cfg_we && !w_cfg_legal;

  assign w_start      = w_is_idle && i_start;

  // r_m is always legal; the i_stim_in column is only consumed when legal.
  assign w_ns         = r_nt[r_m][i_stim_in];
  assign w_exp        = r_ot[r_m];

  assign w_cmp_fail   = r_cmp_pend && (i_dut_out != r_cmp_exp);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ctl <= CTL_IDLE;
    end else begin
      r_ctl <= w_ctl_nxt;
    end
  end

  // DRAIN exits once no vector is outstanding: the compare of the last vector
  // (already in r_cmp_pend) resolves on the same edge that returns to IDLE.
  always_comb begin
    w_ctl_nxt = r_ctl;
    w_done    = 1'b0;
    case (r_ctl)
      CTL_IDLE: begin
        if (i_start) begin
          w_ctl_nxt = CTL_RUN;
        end
      end
      CTL_RUN: begin
        if (i_stop) begin
          w_ctl_nxt = CTL_DRAIN;
        end
      end
      CTL_DRAIN: begin
        if (!r_vec_vld) begin
          w_ctl_nxt = CTL_IDLE;
          w_done    = 1'b1;
        end
      end
      default: begin
        w_ctl_nxt = CTL_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Programmable tables; reset restores self-loops and zero outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NUM_ST; s++) begin
        r_ot[s] <= '0;
        for (int i = 0; i < NUM_ST; i++) begin
          r_nt[s][i] <= ST_W'(s);
        end
      end
    end else if (w_cfg_wr) begin
      if (i_cfg_sel) begin
        r_ot[i_cfg_state] <= i_cfg_data;
      end else begin
        r_nt[i_cfg_state][i_cfg_in] <= i_cfg_data[ST_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Model state, vector issue, status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_m       <= '0;
      r_vec     <= '0;
      r_vec_vld <= 1'b0;
      r_cfg_err <= 1'b0;
      r_in_err  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_vec_vld <= w_issue;
      r_cfg_err <= w_cfg_bad;
      r_in_err  <= w_stim_bad;
      r_done    <= w_done;

      if (w_start) begin
        r_m <= '0;
      end else if (w_issue) begin
        r_m <= w_ns;
      end

      // Vector fields hold their last value when nothing is issued.
      if (w_issue) begin
        r_vec <= '{in_drv: i_stim_in, cs: r_m, ns: w_ns, exp_out: w_exp};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare pipeline: vector at cycle t, DUT output checked at end of t+1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cmp_pend <= 1'b0;
      r_cmp_exp  <= '0;
      r_mismatch <= 1'b0;
      r_mm_cnt   <= '0;
    end else begin
      r_cmp_pend <= r_vec_vld;
      if (r_vec_vld) begin
        r_cmp_exp <= r_vec.exp_out;
      end

      // The pulse fires on every failure even once the counter has saturated.
      r_mismatch <= w_cmp_fail;

      if (w_start) begin
        r_mm_cnt <= '0;
      end else if (w_cmp_fail && (r_mm_cnt != '1)) begin
        r_mm_cnt <= r_mm_cnt + ERR_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_vec_valid    = r_vec_vld;
  assign o_in_drv       = r_vec.in_drv;
  assign o_cs           = r_vec.cs;
  assign o_ns           = r_vec.ns;
  assign o_exp_out      = r_vec.exp_out;
  assign o_cfg_err      = r_cfg_err;
  assign o_in_err       = r_in_err;
  assign o_mismatch     = r_mismatch;
  assign o_mismatch_cnt = r_mm_cnt;
  assign o_done         = r_done;

endmodule

// File: tb/tb_fsm_vector_gen.sv
// Purpose: directed, table-driven bench for fsm_vector_gen.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_fsm_vector_gen;

  logic       clk;
  logic       reset_n;
  logic       cfg_we;
  logic       cfg_sel;
  logic [2:0] cfg_state;
  logic [2:0] cfg_in;
  logic [3:0] cfg_data;
  logic       start;
  logic       stop;
  logic       stim_valid;
  logic [2:0] stim_in;
  logic [3:0] dut_out;

  logic       o_vec_valid;
  logic [2:0] o_in_drv;
  logic [2:0] o_cs;
  logic [2:0] o_ns;
  logic [3:0] o_exp_out;
  logic       o_cfg_err;
  logic       o_in_err;
  logic       o_mismatch;
  logic [7:0] o_mismatch_cnt;
  logic       o_done;

  int n_chk;
  int n_err;

  fsm_vector_gen #(
    .NUM_ST(5),
    .ST_W  (3),
    .OUT_W (4),
    .ERR_W (8)
  ) u_dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_cfg_we       (cfg_we),
    .i_cfg_sel      (cfg_sel),
    .i_cfg_state    (cfg_state),
    .i_cfg_in       (cfg_in),
    .i_cfg_data     (cfg_data),
    .i_start        (start),
    .i_stop         (stop),
    .i_stim_valid   (stim_valid),
    .i_stim_in      (stim_in),
    .i_dut_out      (dut_out),
    .o_vec_valid    (o_vec_valid),
    .o_in_drv       (o_in_drv),
    .o_cs           (o_cs),
    .o_ns           (o_ns),
    .o_exp_out      (o_exp_out),
    .o_cfg_err      (o_cfg_err),
    .o_in_err       (o_in_err),
    .o_mismatch     (o_mismatch),
    .o_mismatch_cnt (o_mismatch_cnt),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row: inputs for a cycle, then outputs expected right after its edge.
  typedef struct {
    logic       sv;
    logic [2:0] in;
    logic [3:0] dut;
    logic       vld;
    logic [2:0] e_in;
    logic [2:0] cs;
    logic [2:0] ns;
    logic [3:0] ex;
    logic       ie;
    logic       mm;
    logic [7:0] cnt;
  } row_t;

  row_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_we     = 1'b0;
    cfg_sel    = 1'b0;
    cfg_state  = 3'd0;
    cfg_in     = 3'd0;
    cfg_data   = 4'd0;
    start      = 1'b0;
    stop       = 1'b0;
    stim_valid = 1'b0;
    stim_in    = 3'd0;
    dut_out    = 4'd0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " vec_valid"}, 32'(o_vec_valid), 32'd0);
    chk({tag, " in_drv"},    32'(o_in_drv),    32'd0);
    chk({tag, " cs"},        32'(o_cs),        32'd0);
    chk({tag, " ns"},        32'(o_ns),        32'd0);
    chk({tag, " exp_out"},   32'(o_exp_out),   32'd0);
    chk({tag, " cfg_err"},   32'(o_cfg_err),   32'd0);
    chk({tag, " in_err"},    32'(o_in_err),    32'd0);
    chk({tag, " mismatch"},  32'(o_mismatch),  32'd0);
    chk({tag, " mm_cnt"},    32'(o_mismatch_cnt), 32'd0);
    chk({tag, " done"},      32'(o_done),      32'd0);
  endtask

  task automatic cfg_wr(input logic sel, input logic [2:0] st, input logic [2:0] col,
                        input logic [3:0] d, input logic e_err, input string nm);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_state = st;
    cfg_in    = col;
    cfg_data  = d;
    tick();
    cfg_we    = 1'b0;
    chk(nm, 32'(o_cfg_err), 32'(e_err));
  endtask

  task automatic chk_vec(input string tag, input logic [2:0] e_in, input logic [2:0] e_cs,
                         input logic [2:0] e_ns, input logic [3:0] e_ex);
    chk({tag, " vld"},    32'(o_vec_valid), 32'd1);
    chk({tag, " in_drv"}, 32'(o_in_drv),    32'(e_in));
    chk({tag, " cs"},     32'(o_cs),        32'(e_cs));
    chk({tag, " ns"},     32'(o_ns),        32'(e_ns));
    chk({tag, " exp"},    32'(o_exp_out),   32'(e_ex));
  endtask

  // Safety net: the run is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end well before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;

    // Ring 0->1->2->3->4->0 on input 1, OT[s] = s+1. dut_out row r echoes
    // exp_out of row r-2 (one cycle after that vector was presented).
    //            sv    in    dut    vld   e_in  cs    ns    ex     ie    mm    cnt
    tbl[0]  = '{1'b1, 3'd1, 4'd0,  1'b1, 3'd1, 3'd0, 3'd1, 4'd1,  1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 3'd1, 4'd0,  1'b1, 3'd1, 3'd1, 3'd2, 4'd2,  1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 3'd1, 4'd1,  1'b1, 3'd1, 3'd2, 3'd3, 4'd3,  1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 3'd1, 4'd2,  1'b1, 3'd1, 3'd3, 3'd4, 4'd4,  1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 3'd1, 4'd3,  1'b1, 3'd1, 3'd4, 3'd0, 4'd5,  1'b0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 3'd1, 4'd4,  1'b1, 3'd1, 3'd0, 3'd1, 4'd1,  1'b0, 1'b0, 8'd0};
    // illegal symbol: no vector, fields hold, in_err pulses
    tbl[6]  = '{1'b1, 3'd5, 4'd5,  1'b0, 3'd1, 3'd0, 3'd1, 4'd1,  1'b1, 1'b0, 8'd0};
    // model state unchanged by the illegal symbol
    tbl[7]  = '{1'b1, 3'd1, 4'd1,  1'b1, 3'd1, 3'd1, 3'd2, 4'd2,  1'b0, 1'b0, 8'd0};
    // no compare due (row 6 issued nothing), so a wrong dut_out is harmless
    tbl[8]  = '{1'b0, 3'd0, 4'hF,  1'b0, 3'd1, 3'd1, 3'd2, 4'd2,  1'b0, 1'b0, 8'd0};
    // row 7 expected 2, DUT shows F -> one mismatch
    tbl[9]  = '{1'b0, 3'd0, 4'hF,  1'b0, 3'd1, 3'd1, 3'd2, 4'd2,  1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 3'd0, 4'd0,  1'b0, 3'd1, 3'd1, 3'd2, 4'd2,  1'b0, 1'b0, 8'd1};

    idle_in();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    tick();

    // IDLE: stimulus without start issues nothing
    stim_valid = 1'b1;
    stim_in    = 3'd1;
    tick();
    chk("idle_no_vec", 32'(o_vec_valid), 32'd0);
    stim_valid = 1'b0;

    // Program the ring
    for (int s = 0; s < 5; s++) begin
      cfg_wr(1'b0, 3'(s), 3'd1, 4'((s + 1) % 5), 1'b0, $sformatf("cfg_nt%0d", s));
      cfg_wr(1'b1, 3'(s), 3'd0, 4'(s + 1),       1'b0, $sformatf("cfg_ot%0d", s));
    end

    // Illegal writes
    cfg_wr(1'b0, 3'd0, 3'd1, 4'd6, 1'b1, "cfg_bad_data");
    tick();
    chk("cfg_err_pulse_end", 32'(o_cfg_err), 32'd0);
    cfg_wr(1'b1, 3'd5, 3'd0, 4'd9, 1'b1, "cfg_bad_state");
    cfg_wr(1'b0, 3'd0, 3'd7, 4'd1, 1'b1, "cfg_bad_in");

    // Start
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start vld", 32'(o_vec_valid), 32'd0);
    chk("start cnt", 32'(o_mismatch_cnt), 32'd0);

    // Ring run / illegal stimulus / single forced mismatch
    for (int r = 0; r < 11; r++) begin
      stim_valid = tbl[r].sv;
      stim_in    = tbl[r].in;
      dut_out    = tbl[r].dut;
      tick();
      chk($sformatf("r%0d vld", r),    32'(o_vec_valid),    32'(tbl[r].vld));
      chk($sformatf("r%0d in_drv", r), 32'(o_in_drv),       32'(tbl[r].e_in));
      chk($sformatf("r%0d cs", r),     32'(o_cs),           32'(tbl[r].cs));
      chk($sformatf("r%0d ns", r),     32'(o_ns),           32'(tbl[r].ns));
      chk($sformatf("r%0d exp", r),    32'(o_exp_out),      32'(tbl[r].ex));
      chk($sformatf("r%0d in_err", r), 32'(o_in_err),       32'(tbl[r].ie));
      chk($sformatf("r%0d mm", r),     32'(o_mismatch),     32'(tbl[r].mm));
      chk($sformatf("r%0d cnt", r),    32'(o_mismatch_cnt), 32'(tbl[r].cnt));
    end

    // Saturation: input 0 self-loops at state 2 (exp 3); DUT stuck at F.
    // Compares start on the 3rd edge, so 100 edges add 98 mismatches.
    stim_valid = 1'b1;
    stim_in    = 3'd0;
    dut_out    = 4'hF;
    repeat (100) tick();
    chk("sat_mid cnt", 32'(o_mismatch_cnt), 32'd99);
    repeat (200) tick();
    chk("sat cnt", 32'(o_mismatch_cnt), 32'd255);
    chk("sat mm",  32'(o_mismatch),     32'd1);
    stim_valid = 1'b0;

    // Config writes in RUN are ignored without error
    cfg_wr(1'b0, 3'd2, 3'd1, 4'd0, 1'b0, "run_cfg_legal");
    cfg_wr(1'b0, 3'd0, 3'd0, 4'd6, 1'b0, "run_cfg_bad");

    // stop together with a stimulus: vector still issued, done two cycles later
    stop       = 1'b1;
    stim_valid = 1'b1;
    stim_in    = 3'd1;
    tick();
    stop       = 1'b0;
    stim_valid = 1'b0;
    chk_vec("stop_vec", 3'd1, 3'd2, 3'd3, 4'd3);
    chk("stop done0", 32'(o_done), 32'd0);
    tick();
    chk("drain vld", 32'(o_vec_valid), 32'd0);
    chk("drain done1", 32'(o_done), 32'd0);
    tick();
    chk("drain done2", 32'(o_done), 32'd1);
    chk("drain cnt", 32'(o_mismatch_cnt), 32'd255);
    tick();
    chk("done pulse end", 32'(o_done), 32'd0);

    // Restart clears the counter; issue a vector, then reset mid-RUN
    dut_out = 4'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("restart cnt", 32'(o_mismatch_cnt), 32'd0);
    stim_valid = 1'b1;
    stim_in    = 3'd1;
    tick();
    chk_vec("pre_rst", 3'd1, 3'd0, 3'd1, 4'd1);
    reset_n = 1'b0;
    #2;
    chk_zero("mid_run_rst");
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst idle", 32'(o_vec_valid), 32'd0);
    stim_valid = 1'b0;

    // Read back row 0: every input must self-loop with output 0
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      stim_valid = 1'b1;
      stim_in    = 3'(i);
      tick();
      chk_vec($sformatf("rb%0d", i), 3'(i), 3'd0, 3'd0, 4'd0);
    end
    stim_valid = 1'b0;
    stop       = 1'b1;
    tick();
    stop       = 1'b0;
    chk("rb drain done0", 32'(o_done), 32'd0);
    tick();
    chk("rb drain done1", 32'(o_done), 32'd1);
    chk("rb cnt", 32'(o_mismatch_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
